// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and constants for the Viterbi frame sequencer.
// Optional build macro used by the sequencer: VITERBI_CTRL_STATS_EN.
package viterbi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [2:0] K_MIN     = 3'd3;
  localparam logic [2:0] K_MAX     = 3'd7;
  localparam logic [1:0] TAIL_ZERO = 2'b00;

  // Start command legality: constraint length in range and a non-empty frame that fits.
  function automatic logic cfg_ok(input int unsigned k, input int unsigned len,
                                  input int unsigned max_len);
    return (k >= 32'(K_MIN)) && (k <= 32'(K_MAX)) && (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol stream handshake into the Viterbi frame sequencer: transfer when valid && ready.
interface viterbi_frame_ctrl_if;
  logic       sym_valid;
  logic       sym_ready;
  logic [1:0] sym_data;

  modport master (output sym_valid, output sym_data, input sym_ready);
  modport slave  (input sym_valid, input sym_data, output sym_ready);
endinterface

// File: rtl/viterbi_valid_delay.sv
// Fixed-depth marker delay line; tracks which decoder output cycles carry info bits.
// DEPTH must be at least 2.
module viterbi_valid_delay #(
  parameter int unsigned DEPTH = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  output logic o_out
);

  logic [DEPTH-1:0] r_sr;

  // Shift one marker per clock; reset empties the line so an aborted frame leaves no strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sr <= '0;
    else        r_sr <= {r_sr[DEPTH-2:0], i_in};
  end

  assign o_out = r_sr[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer in front of decoder_sys: feeds symbol pairs one per clock, appends K-1
// zero tail pairs, waits out the traceback and strobes decoded bits.
// Optional build macro: VITERBI_CTRL_STATS_EN adds o_stat_frames / o_stat_underruns.
module viterbi_frame_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter  int unsigned MAX_FRAME_LEN   = 64,
  parameter  int unsigned TRACEBACK_DEPTH = 15,
  localparam int unsigned FLW             = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [FLW-1:0]       i_frame_len,
  input  logic [2:0]           i_cfg_k,
  output logic                 o_busy,
  output logic                 o_err_cfg,
  output logic                 o_err_underrun,
  viterbi_frame_ctrl_if.slave  sym,
  output logic [1:0]           o_dec_encoded_bits,
  output logic [2:0]           o_dec_choose_k,
  input  logic                 i_dec_final_output,
  output logic                 o_bit_valid,
  output logic                 o_bit_data,
  output logic                 o_frame_done
`ifdef VITERBI_CTRL_STATS_EN
  ,
  output logic [15:0]          o_stat_frames,
  output logic [15:0]          o_stat_underruns
`endif
);

  state_e         r_state;
  logic [FLW-1:0] r_len;
  logic [FLW-1:0] r_cnt;
  logic [FLW-1:0] r_out_cnt;
  logic [2:0]     r_k;
  logic [1:0]     r_dec_bits;
  logic           r_mark;
  logic           r_err_cfg;
  logic           r_err_underrun;

  logic w_cfg_ok;
  logic w_accept;
  logic w_reject;
  logic w_starve;
  logic w_last_slot;
  logic w_last_tail;
  logic w_last_bit;
  logic w_valid_dly;

  assign w_cfg_ok    = cfg_ok(32'(i_cfg_k), 32'(i_frame_len), MAX_FRAME_LEN);
  assign w_accept    = (r_state == IDLE) && i_start &&  w_cfg_ok;
  assign w_reject    = (r_state == IDLE) && i_start && !w_cfg_ok;
  assign w_starve    = (r_state == FEED) && !sym.sym_valid;
  assign w_last_slot = (r_cnt == r_len - FLW'(1));
  assign w_last_tail = (r_cnt == FLW'(r_k) - FLW'(2));
  // Exit DRAIN on the strobe of the frame's final info bit rather than a fixed timer.
  assign w_last_bit  = w_valid_dly && (r_out_cnt == r_len - FLW'(1));

  // Frame sequencing; r_cnt is reused for info slots and then tail slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= FEED;
          r_cnt   <= '0;
        end
        FEED: if (w_last_slot) begin
          r_state <= FLUSH;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + FLW'(1);
        end
        FLUSH: if (w_last_tail) begin
          r_state <= DRAIN;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + FLW'(1);
        end
        DRAIN:   if (w_last_bit) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Frame configuration latched only on an accepted start, held for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_k   <= K_MIN;
    end else if (w_accept) begin
      r_len <= i_frame_len;
      r_k   <= i_cfg_k;
    end
  end

  // Decoder input: a starved FEED slot is still consumed, as a zero pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_bits <= TAIL_ZERO;
      r_mark     <= 1'b0;
    end else begin
      r_dec_bits <= ((r_state == FEED) && sym.sym_valid) ? sym.sym_data : TAIL_ZERO;
      r_mark     <= (r_state == FEED);
    end
  end

  // Error flags and count of info bits already strobed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cfg      <= 1'b0;
      r_err_underrun <= 1'b0;
      r_out_cnt      <= '0;
    end else begin
      r_err_cfg <= w_reject;
      if (w_accept)      r_err_underrun <= 1'b0;
      else if (w_starve) r_err_underrun <= 1'b1;
      if (w_accept)         r_out_cnt <= '0;
      else if (w_valid_dly) r_out_cnt <= r_out_cnt + FLW'(1);
    end
  end

  viterbi_valid_delay #(.DEPTH(TRACEBACK_DEPTH)) u_valid_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_in  (r_mark),
    .o_out (w_valid_dly)
  );

`ifdef VITERBI_CTRL_STATS_EN
  logic [15:0] r_stat_frames;
  logic [15:0] r_stat_underruns;

  // Wrapping activity counters: completed frames and starved FEED slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_frames    <= '0;
      r_stat_underruns <= '0;
    end else begin
      if (r_state == DONE) r_stat_frames    <= r_stat_frames + 16'd1;
      if (w_starve)        r_stat_underruns <= r_stat_underruns + 16'd1;
    end
  end

  assign o_stat_frames    = r_stat_frames;
  assign o_stat_underruns = r_stat_underruns;
`endif

  assign o_busy             = (r_state != IDLE);
  assign sym.sym_ready      = (r_state == FEED);
  assign o_frame_done       = (r_state == DONE);
  assign o_err_cfg          = r_err_cfg;
  assign o_err_underrun     = r_err_underrun;
  assign o_dec_encoded_bits = r_dec_bits;
  assign o_dec_choose_k     = r_k;
  assign o_bit_valid        = w_valid_dly;
  assign o_bit_data         = w_valid_dly & i_dec_final_output;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl with a stand-in decoder_sys of fixed latency.
// Build with VITERBI_CTRL_STATS_EN defined to also check the statistics counters.
module tb_viterbi_frame_ctrl;

  localparam int unsigned MAXL  = 64;
  localparam int unsigned TBD   = 15;
  localparam int unsigned NOGAP = 999;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] frame_len;
  logic [2:0] cfg_k;
  logic       busy, err_cfg, err_underrun;
  logic [1:0] dec_bits;
  logic [2:0] dec_k;
  logic       dec_final;
  logic       bit_valid, bit_data, frame_done;
`ifdef VITERBI_CTRL_STATS_EN
  logic [15:0] stat_frames, stat_underruns;
`endif

  viterbi_frame_ctrl_if sif ();

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.MAX_FRAME_LEN(MAXL), .TRACEBACK_DEPTH(TBD)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_start            (start),
    .i_frame_len        (frame_len),
    .i_cfg_k            (cfg_k),
    .o_busy             (busy),
    .o_err_cfg          (err_cfg),
    .o_err_underrun     (err_underrun),
    .sym                (sif),
    .o_dec_encoded_bits (dec_bits),
    .o_dec_choose_k     (dec_k),
    .i_dec_final_output (dec_final),
    .o_bit_valid        (bit_valid),
    .o_bit_data         (bit_data),
    .o_frame_done       (frame_done)
`ifdef VITERBI_CTRL_STATS_EN
    ,
    .o_stat_frames      (stat_frames),
    .o_stat_underruns   (stat_underruns)
`endif
  );

  // Stand-in decoder: the bit for a pair appears TBD cycles after it is presented,
  // and its value is the XOR of the pair's two code bits.
  logic [1:0] dec_hist [TBD];
  always @(posedge clk) begin
    dec_hist[0] <= dec_bits;
    for (int i = 1; i < TBD; i++) dec_hist[i] <= dec_hist[i-1];
  end
  assign dec_final = ^dec_hist[TBD-1];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [2:0]  cur_k = 3'd3;
  logic        cur_under = 1'b0;
  int unsigned exp_frames = 0;
  int unsigned exp_unders = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_stats();
`ifdef VITERBI_CTRL_STATS_EN
    check_eq("stat_frames", 32'(stat_frames), 32'(16'(exp_frames)));
    check_eq("stat_underruns", 32'(stat_underruns), 32'(16'(exp_unders)));
`endif
  endtask

  task automatic check_idle(input logic exp_err);
    check_eq("busy", 32'(busy), 0);
    check_eq("sym_ready", 32'(sif.sym_ready), 0);
    check_eq("dec_bits", 32'(dec_bits), 0);
    check_eq("bit_valid", 32'(bit_valid), 0);
    check_eq("bit_data", 32'(bit_data), 0);
    check_eq("frame_done", 32'(frame_done), 0);
    check_eq("err_cfg", 32'(err_cfg), 32'(exp_err));
    check_eq("err_underrun", 32'(err_underrun), 32'(cur_under));
    check_eq("choose_k", 32'(dec_k), 32'(cur_k));
    check_stats();
  endtask

  task automatic drive_idle();
    start         = 1'b0;
    frame_len     = 7'($urandom);
    cfg_k         = 3'($urandom);
    sif.sym_valid = 1'($urandom);
    sif.sym_data  = 2'($urandom);
  endtask

  task automatic idle(input int unsigned m);
    for (int unsigned i = 0; i < m; i++) begin
      @(posedge clk); #1; drive_idle();
      @(negedge clk); check_idle(1'b0);
    end
  endtask

  task automatic reject(input int unsigned len, input int unsigned k);
    @(posedge clk); #1; drive_idle();
    start = 1'b1; frame_len = 7'(len); cfg_k = 3'(k);
    @(negedge clk); check_idle(1'b0);
    @(posedge clk); #1; drive_idle();
    @(negedge clk); check_idle(1'b1);
    @(posedge clk); #1; drive_idle();
    @(negedge clk); check_idle(1'b0);
  endtask

  // One whole frame, cycle n relative to the start cycle (n=0). Model timeline:
  // info slot i is on the decoder input at n=i+2, its bit strobes at n=i+17,
  // frame_done at n=L+17, busy low again at n=L+18 (the next frame's n=0).
  task automatic run_frame(input int unsigned len, input int unsigned k, input int unsigned gap_pct,
                           input int unsigned force_gap, input logic [127:0] fix, input bit use_fix);
    logic [1:0]  pdata [MAXL];
    logic        pval  [MAXL];
    logic        under;
    logic [1:0]  pair;
    logic        expv;
    logic        expb;
    int unsigned pulses;
    int unsigned gaps;
    under = 1'b0; pulses = 0; gaps = 0;
    for (int unsigned i = 0; i < len; i++) begin
      pdata[i] = use_fix ? fix[2*i +: 2] : 2'($urandom);
      pval[i]  = ($urandom_range(0, 99) >= gap_pct) && (i != force_gap);
      if (!pval[i]) gaps++;
    end
    for (int unsigned n = 0; n <= len + 17; n++) begin
      @(posedge clk); #1; drive_idle();
      if (n == 0) begin
        start = 1'b1; frame_len = 7'(len); cfg_k = 3'(k);
      end else begin
        start = ($urandom_range(0, 3) == 0);
      end
      if (n >= 1 && n <= len) begin
        sif.sym_valid = pval[n-1];
        sif.sym_data  = pdata[n-1];
      end
      @(negedge clk);
      if (n == 0) begin
        check_idle(1'b0);
      end else begin
        pair = 2'b00;
        if (n >= 2 && n <= len + 1) begin
          if (pval[n-2]) pair = pdata[n-2];
          else           under = 1'b1;
        end
        expv = (n >= 17) && (n <= len + 16);
        expb = 1'b0;
        if (expv) expb = pval[n-17] ? ^pdata[n-17] : 1'b0;
        if (bit_valid) pulses++;
        check_eq("busy", 32'(busy), 1);
        check_eq("sym_ready", 32'(sif.sym_ready), 32'(n <= len));
        check_eq("dec_bits", 32'(dec_bits), 32'(pair));
        check_eq("bit_valid", 32'(bit_valid), 32'(expv));
        check_eq("bit_data", 32'(bit_data), 32'(expb));
        check_eq("frame_done", 32'(frame_done), 32'(n == len + 17));
        check_eq("err_cfg", 32'(err_cfg), 0);
        check_eq("err_underrun", 32'(err_underrun), 32'(under));
        check_eq("choose_k", 32'(dec_k), k);
      end
    end
    check_eq("bit_count", pulses, len);
    cur_k      = 3'(k);
    cur_under  = under;
    exp_frames = exp_frames + 1;
    exp_unders = exp_unders + gaps;
  endtask

  logic [127:0] t1_pairs;

  initial begin
    t1_pairs = 128'(14'b11_11_10_10_01_10_11);
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk); check_idle(1'b0);
    rst_n = 1'b1;
    idle(3);

    // Test 1: K=3, 7 gapless pairs.
    run_frame(7, 3, 0, NOGAP, t1_pairs, 1'b1);
    idle(2);

    // Test 2: illegal configurations are rejected with a single err_cfg pulse.
    reject(5, 2);
    reject(0, 3);
    reject(65, 4);
    reject(10, 0);

    // Test 3: starved second slot.
    run_frame(4, 3, 0, 1, '0, 1'b0);
    idle(1);

    // Test 4: back-to-back K=3 then K=5 frames.
    run_frame(9, 3, 0, NOGAP, '0, 1'b0);
    run_frame(12, 5, 0, NOGAP, '0, 1'b0);
    idle(2);

    // Test 5: asynchronous reset in the middle of FEED.
    @(posedge clk); #1; drive_idle();
    start = 1'b1; frame_len = 7'd10; cfg_k = 3'd4;
    repeat (3) begin
      @(posedge clk); #1; drive_idle(); sif.sym_valid = 1'b1;
    end
    @(posedge clk); #1; drive_idle();
    #1; check_eq("busy_pre_reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    cur_k = 3'd3; cur_under = 1'b0; exp_frames = 0; exp_unders = 0;
    check_idle(1'b0);
    @(posedge clk); #1; drive_idle();
    @(negedge clk); check_idle(1'b0);
    rst_n = 1'b1;
    idle(20);
    run_frame(7, 3, 0, NOGAP, t1_pairs, 1'b1);

    // Test 6: maximum frame length with K=7.
    run_frame(64, 7, 0, NOGAP, '0, 1'b0);

    // Randomised frames with occasional gaps and random idle spacing.
    for (int r = 0; r < 8; r++) begin
      run_frame($urandom_range(1, 64), $urandom_range(3, 7), 15, NOGAP, '0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
